// File: rtl/decoder_pkg.sv
// decoder_pkg: shared constants and helpers for the scan_decoder block.
// Provides the mode encodings, a bounded one-hot helper and a width helper.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Smallest w such that 2**w >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // One-hot code for idx over num_out outputs; out-of-range idx gives all zero.
  function automatic logic [31:0] onehot(input logic [31:0] idx, input int num_out);
    logic [31:0] result;
    result = '0;
    if (idx < 32'(num_out)) result = 32'd1 << idx;
    return result;
  endfunction

endpackage

// File: rtl/scan_decoder_dwell_counter.sv
// dwell_counter: prescaler that counts 0..DWELL-1 while enabled and flags the
// last count with tick, so the owner knows when to advance its index.
module dwell_counter
  import decoder_pkg::*;
#(
  parameter int DWELL = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DWELL > 1) ? clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = en && (count_q == LAST);

  // Next count: clear wins, otherwise roll over at the last count while enabled.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered SEL_W-to-NUM_OUT one-hot decoder with a direct mode
// (sel picks the output) and a scan mode (index rotates every DWELL cycles).
// Optional build macro SCAN_BLANK_EN inserts one all-zero blanking cycle at
// every scan index change; the default build switches outputs directly.
module scan_decoder
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 4,
  parameter int DWELL   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] out,
  output logic [SEL_W-1:0]   cur_idx,
  output logic               wrap
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);

  logic               mode_q,    mode_d;
  logic [SEL_W-1:0]   idx_q,     idx_d;
  logic [NUM_OUT-1:0] out_q,     out_d;
  logic [SEL_W-1:0]   cur_idx_q, cur_idx_d;
  logic               wrap_q,    wrap_d;
`ifdef SCAN_BLANK_EN
  logic               blank_q,   blank_d;
`endif

  logic             entry;
  logic             scanning;
  logic             pre_clr;
  logic             pre_en;
  logic             tick;
  logic [SEL_W-1:0] idx_next;
  logic [SEL_W-1:0] entry_idx;

  // A scan entry is the first enabled cycle in scan mode after direct mode.
  assign entry     = en && (mode == MODE_SCAN) && (mode_q == MODE_DIRECT);
  assign scanning  = en && (mode == MODE_SCAN) && (mode_q == MODE_SCAN);
  assign pre_clr   = en && ((mode == MODE_DIRECT) || entry);
`ifdef SCAN_BLANK_EN
  assign pre_en    = scanning && !blank_q;
`else
  assign pre_en    = scanning;
`endif
  assign idx_next  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  assign entry_idx = (32'(sel) < 32'(NUM_OUT)) ? sel : '0;

  dwell_counter #(
    .DWELL(DWELL)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (pre_clr),
    .en  (pre_en),
    .tick(tick)
  );

  // Next-state decode for mode tracking, scan index and all registered outputs.
  always_comb begin
    mode_d    = mode_q;
    idx_d     = idx_q;
    out_d     = out_q;
    cur_idx_d = cur_idx_q;
    wrap_d    = 1'b0;
`ifdef SCAN_BLANK_EN
    blank_d   = blank_q;
`endif
    if (!en) begin
      out_d = '0;
    end else if (mode == MODE_DIRECT) begin
      mode_d    = MODE_DIRECT;
      out_d     = NUM_OUT'(onehot(32'(sel), NUM_OUT));
      cur_idx_d = sel;
`ifdef SCAN_BLANK_EN
      blank_d   = 1'b0;
`endif
    end else if (entry) begin
      mode_d    = MODE_SCAN;
      idx_d     = entry_idx;
      cur_idx_d = entry_idx;
      out_d     = NUM_OUT'(onehot(32'(entry_idx), NUM_OUT));
`ifdef SCAN_BLANK_EN
      blank_d   = 1'b0;
`endif
    end else begin
`ifdef SCAN_BLANK_EN
      if (blank_q) begin
        blank_d = 1'b0;
        out_d   = NUM_OUT'(onehot(32'(idx_q), NUM_OUT));
      end else if (tick) begin
        idx_d     = idx_next;
        cur_idx_d = idx_next;
        wrap_d    = (idx_next == '0);
        out_d     = '0;
        blank_d   = 1'b1;
      end else begin
        out_d = NUM_OUT'(onehot(32'(idx_q), NUM_OUT));
      end
`else
      if (tick) begin
        idx_d     = idx_next;
        cur_idx_d = idx_next;
        wrap_d    = (idx_next == '0);
        out_d     = NUM_OUT'(onehot(32'(idx_next), NUM_OUT));
      end else begin
        out_d = NUM_OUT'(onehot(32'(idx_q), NUM_OUT));
      end
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_DIRECT;
      idx_q     <= '0;
      out_q     <= '0;
      cur_idx_q <= '0;
      wrap_q    <= 1'b0;
`ifdef SCAN_BLANK_EN
      blank_q   <= 1'b0;
`endif
    end else begin
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      out_q     <= out_d;
      cur_idx_q <= cur_idx_d;
      wrap_q    <= wrap_d;
`ifdef SCAN_BLANK_EN
      blank_q   <= blank_d;
`endif
    end
  end

  assign out     = out_q;
  assign cur_idx = cur_idx_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: scoreboard bench for scan_decoder. Two instances share the
// stimulus: A (NUM_OUT=4, DWELL=3) and B (NUM_OUT=3, DWELL=1). Expected
// responses come from a model that tracks elapsed scan time since entry and
// derives index, blanking and wrap from it arithmetically.
module tb_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en;
  logic       mode;
  logic [1:0] sel;

  logic [3:0] outA;
  logic [1:0] curA;
  logic       wrapA;
  logic [2:0] outB;
  logic [1:0] curB;
  logic       wrapB;

  scan_decoder #(.SEL_W(2), .NUM_OUT(4), .DWELL(3)) dutA (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .out(outA), .cur_idx(curA), .wrap(wrapA)
  );

  scan_decoder #(.SEL_W(2), .NUM_OUT(3), .DWELL(1)) dutB (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .out(outB), .cur_idx(curB), .wrap(wrapB)
  );

`ifdef SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef struct {
    logic [3:0] out;
    logic [1:0] cur;
    logic       wrap;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];

  int checks   = 0;
  int failures = 0;

  // Reference state per instance: scanning flag, start index, elapsed scan
  // cycles since entry, and the index last reported.
  int numOut[2] = '{4, 3};
  int dwell[2]  = '{3, 1};
  int scanOn[2] = '{0, 0};
  int start[2]  = '{0, 0};
  int elapsed[2] = '{0, 0};
  int curIdx[2] = '{0, 0};

  task automatic modelStep(input int k, output exp_t ex);
    int slot;
    int idx;
    bit blank;
    bit first;
    ex.wrap = 1'b0;
    ex.out  = 4'd0;
    if (rst) begin
      scanOn[k] = 0; start[k] = 0; elapsed[k] = 0; curIdx[k] = 0;
    end else if (!en) begin
      ex.out = 4'd0;
    end else if (mode == 1'b0) begin
      scanOn[k] = 0;
      curIdx[k] = int'(sel);
      if (int'(sel) < numOut[k]) ex.out = 4'(1 << int'(sel));
    end else if (scanOn[k] == 0) begin
      scanOn[k]  = 1;
      start[k]   = (int'(sel) < numOut[k]) ? int'(sel) : 0;
      elapsed[k] = 0;
      curIdx[k]  = start[k];
      ex.out     = 4'(1 << start[k]);
    end else begin
      elapsed[k]++;
      if (!BLANK) begin
        slot  = elapsed[k] / dwell[k];
        first = (elapsed[k] % dwell[k]) == 0;
        blank = 1'b0;
      end else if (elapsed[k] < dwell[k]) begin
        slot  = 0;
        first = (elapsed[k] == 0);
        blank = 1'b0;
      end else begin
        slot  = 1 + (elapsed[k] - dwell[k]) / (dwell[k] + 1);
        blank = ((elapsed[k] - dwell[k]) % (dwell[k] + 1)) == 0;
        first = blank;
      end
      idx       = (start[k] + slot) % numOut[k];
      curIdx[k] = idx;
      ex.out    = blank ? 4'd0 : 4'(1 << idx);
      ex.wrap   = first && (slot > 0) && (idx == 0);
    end
    ex.cur = 2'(curIdx[k]);
  endtask

  // Drive one cycle of inputs away from the edge, then record the expected
  // response of both instances for that edge.
  task automatic applyStimulus(input logic r, input logic e, input logic m, input logic [1:0] s);
    exp_t exA;
    exp_t exB;
    @(negedge clk);
    #1;
    rst = r; en = e; mode = m; sel = s;
    @(posedge clk);
    modelStep(0, exA);
    modelStep(1, exB);
    qA.push_back(exA);
    qB.push_back(exB);
  endtask

  task automatic checkOutput(input string name, input exp_t ex,
                             input logic [3:0] aOut, input logic [1:0] aCur, input logic aWrap);
    checks++;
    if (aOut !== ex.out || aCur !== ex.cur || aWrap !== ex.wrap) begin
      failures++;
      $display("[TB] FAIL %s t=%0t got out=%b cur=%0d wrap=%b expected out=%b cur=%0d wrap=%b",
               name, $time, aOut, aCur, aWrap, ex.out, ex.cur, ex.wrap);
    end
    checks++;
    if ($countones(aOut) > 1) begin
      failures++;
      $display("[TB] FAIL %s_onehot t=%0t got out=%b expected at most one bit set", name, $time, aOut);
    end
  endtask

  // Monitor: every output cycle pops the oldest expectation per instance.
  initial begin
    forever begin
      @(negedge clk);
      if (qA.size() > 0) checkOutput("instA", qA.pop_front(), outA, curA, wrapA);
      if (qB.size() > 0) checkOutput("instB", qB.pop_front(), {1'b0, outB}, curB, wrapB);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog t=%0t got no completion expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic m;
    rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 2'd0;
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0);

    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1, 1'b1, 2'd2);

    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0, 2'(s));

    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b1, 2'd0);

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, 2'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd3);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b1, 2'd0);

    m = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) m = ~m;
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), m,
                    2'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 5 && (qA.size() > 0 || qB.size() > 0); i++) @(negedge clk);
    #2;
    checks++;
    if (qA.size() != 0 || qB.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain got pending=%0d expected pending=0", qA.size() + qB.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
